// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter: turns the read side of a 1-cycle-latency FIFO into a
// valid/ready stream. A 2-entry skid buffer plus an inflight flag lets the
// adapter issue a read every cycle when downstream is always ready.
//
// Handshake: a beat transfers on the rising edge where m_valid_o && m_ready_i.
// m_valid_o never drops and m_data_o never changes while m_valid_o=1 and
// m_ready_i=0. fifo_rd_en_o is a request; the word arrives on fifo_rdata_i
// one cycle later and is captured at the following edge.
module fifo_rd_adapter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    output logic                 fifo_rd_en_o,
    input  logic                 flush_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o,
    output logic [1:0]           occ_dbg_o,
    output logic                 inflight_dbg_o
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e                 occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;

    logic       pop;
    logic       capture;
    logic [2:0] pending;

    assign m_valid_o      = (occ_q != OCC_EMPTY);
    assign m_data_o       = head_q;
    assign beat_cnt_o     = beat_q;
    assign occ_dbg_o      = occ_q;
    assign inflight_dbg_o = inflight_q;

    // Read issue: only request when the buffer is guaranteed to have room
    // for the returning word, counting the slot freed by this cycle's pop.
    always_comb begin
        pop          = m_valid_o && m_ready_i;
        capture      = inflight_q;
        pending      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en_o = !fifo_empty_i && !flush_i && !rst_i && (pending < 3'd2);
    end

    // Next-state for occupancy, buffer entries, inflight flag and beat counter.
    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_rd_en_o;
        head_d     = head_q;
        tail_d     = tail_q;
        beat_d     = beat_q;

        // A completed downstream handshake counts even when flushed.
        if (pop) begin
            beat_d = beat_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end

        if (flush_i) begin
            // Drop buffered words and any word returning this edge.
            occ_d      = OCC_EMPTY;
            inflight_d = 1'b0;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (capture) begin
                        head_d = fifo_rdata_i;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (capture && pop) begin
                        head_d = fifo_rdata_i;
                    end else if (capture) begin
                        tail_d = fifo_rdata_i;
                        occ_d  = OCC_FULL;
                    end else if (pop) begin
                        occ_d  = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // No read can be outstanding while full, so only a pop
                    // moves this state.
                    if (pop) begin
                        head_d = tail_q;
                        occ_d  = OCC_ONE;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a small FIFO read-side model feeds the DUT, an
// expected-output queue is filled by the directed tests, and a monitor pops
// and compares on every downstream handshake.
module tb_fifo_rd_adapter;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata = '0;
    logic          fifo_rd_en;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] beat_cnt;
    logic [1:0]    occ_dbg;
    logic          inflight_dbg;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    fifo_rd_adapter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fifo_empty_i   (fifo_empty),
        .fifo_rdata_i   (fifo_rdata),
        .fifo_rd_en_o   (fifo_rd_en),
        .flush_i        (flush),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .beat_cnt_o     (beat_cnt),
        .occ_dbg_o      (occ_dbg),
        .inflight_dbg_o (inflight_dbg)
    );

    // upstream FIFO model: 1-cycle read latency
    logic [W-1:0] fifo_mem [64];
    int fifo_len = 0;
    int rd_ptr   = 0;
    int rd_count = 0;
    assign fifo_empty = (rd_ptr >= fifo_len);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            total = total + 1;
            if (fifo_empty) begin
                bad = bad + 1;
                $display("FAIL rd_underflow: read issued with fifo empty at %0t", $time);
            end
            fifo_rdata <= fifo_mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
            rd_count   <= rd_count + 1;
        end
    end

    // monitor: compare every handshake against the expected queue
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL out_unexpected: got %02h, expected nothing", m_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    bad = bad + 1;
                    $display("FAIL out_data: got %02h, expected %02h", m_data, e);
                end
            end
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w);
        fifo_mem[fifo_len] = w;
        fifo_len = fifo_len + 1;
    endtask

    task automatic expect_out(input logic [W-1:0] w);
        exp_q.push_back(w);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int base;
    logic exp_rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        cyc(2);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_beat", beat_cnt, 0);
        check("rst_data", m_data, 0);
        rst = 1'b0;
        cyc(1);

        // stream at full throughput
        m_ready = 1'b1;
        load(8'h11); load(8'h22); load(8'h33);
        expect_out(8'h11); expect_out(8'h22); expect_out(8'h33);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stream_rd_en_%0d", i), fifo_rd_en, exp_rd[i]);
            check($sformatf("stream_valid_%0d", i), m_valid, exp_v[i]);
        end
        check("stream_beat", beat_cnt, 3);
        cyc(1);

        // backpressure: only two reads while stalled
        m_ready = 1'b0;
        base = rd_count;
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        expect_out(8'hA1); expect_out(8'hA2); expect_out(8'hA3); expect_out(8'hA4);
        cyc(6);
        check("bp_reads", rd_count - base, 2);
        check("bp_occ", occ_dbg, 2);
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 8'hA1);
        cyc(2);
        check("bp_data_hold", m_data, 8'hA1);
        m_ready = 1'b1;
        cyc(8);
        check("bp_reads_all", rd_count - base, 4);
        check("bp_beat", beat_cnt, 7);
        check("bp_drained", exp_q.size(), 0);

        // empty FIFO: nothing happens
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("empty_rd_en", fifo_rd_en, 0);
            check("empty_valid", m_valid, 0);
        end
        cyc(1);

        // flush while full, with a handshake on the flush edge
        m_ready = 1'b0;
        base = rd_count;
        load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
        cyc(3);
        check("fl_full_occ", occ_dbg, 2);
        flush   = 1'b1;
        m_ready = 1'b1;
        expect_out(8'hC1);
        check("fl_rd_en", fifo_rd_en, 0);
        cyc(1);
        flush = 1'b0;
        check("fl_valid", m_valid, 0);
        check("fl_beat", beat_cnt, 8);
        expect_out(8'hC3); expect_out(8'hC4);
        cyc(8);
        check("fl_beat_after", beat_cnt, 10);
        check("fl_reads", rd_count - base, 4);
        check("fl_drained", exp_q.size(), 0);

        // flush with one buffered word and a read in flight
        m_ready = 1'b0;
        base = rd_count;
        load(8'hD1); load(8'hD2); load(8'hD3);
        cyc(2);
        check("fl2_occ", occ_dbg, 1);
        check("fl2_inflight", inflight_dbg, 1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("fl2_valid", m_valid, 0);
        check("fl2_inflight_clr", inflight_dbg, 0);
        expect_out(8'hD3);
        m_ready = 1'b1;
        cyc(6);
        check("fl2_beat", beat_cnt, 11);
        check("fl2_reads", rd_count - base, 3);
        check("fl2_drained", exp_q.size(), 0);

        // reset mid-stream
        m_ready = 1'b0;
        base = rd_count;
        load(8'hE1); load(8'hE2); load(8'hE3);
        cyc(2);
        check("mr_occ", occ_dbg, 1);
        check("mr_inflight", inflight_dbg, 1);
        rst = 1'b1;
        check("mr_rd_en_now", fifo_rd_en, 0);
        cyc(1);
        check("mr_valid", m_valid, 0);
        check("mr_beat", beat_cnt, 0);
        check("mr_data", m_data, 0);
        check("mr_rd_en", fifo_rd_en, 0);
        cyc(1);
        check("mr_reads", rd_count - base, 2);
        rst = 1'b0;
        expect_out(8'hE3);
        m_ready = 1'b1;
        cyc(5);
        check("mr_beat_after", beat_cnt, 1);

        // counter wrap: 16 more beats make 17 since reset
        for (int i = 0; i < 16; i++) begin
            load(8'h40 + 8'(i));
            expect_out(8'h40 + 8'(i));
        end
        cyc(25);
        check("wrap_beat", beat_cnt, 1);
        check("wrap_reads", rd_count - base, 19);
        check("wrap_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
